// File: rtl/shifter_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | shifter_pkg : shared constants, state encodings and helpers for the     |
// |               shared iterative log shifter                              |
// | Revision    : 1.0                                                       |
// +-------------------------------------------------------------------------+
package shifter_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int SHAMT_W_DEF = 5;
  localparam int MAX_WIDTH   = 64;

  // Bit positions inside the 2-bit control field
  localparam int CTL_RIGHT = 1;
  localparam int CTL_ARITH = 0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_STAGE = 2'd1;
  localparam logic [1:0] ST_FLIP  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Reverses the low w bits of v; bits above w come back as zero.
  function automatic logic [MAX_WIDTH-1:0] bit_reverse(input logic [MAX_WIDTH-1:0] v,
                                                       input int                   w);
    logic [MAX_WIDTH-1:0] r;
    r = {<<{v}};
    return r >> (MAX_WIDTH - w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_stage.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | shift_stage : one log-shifter stage, left shift by 2^k with fill        |
// | Revision    : 1.0                                                       |
// +-------------------------------------------------------------------------+
module shift_stage #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [WIDTH-1:0]   in,
  input  logic [SHAMT_W-1:0] k,
  input  logic               en,
  input  logic               fill,
  output logic [WIDTH-1:0]   out
);

  logic [WIDTH-1:0] w_dist;
  logic [WIDTH-1:0] w_fill_mask;

  always_comb begin
    w_dist      = WIDTH'(1) << k;
    // Ones in exactly the bit positions vacated by the shift
    w_fill_mask = ~({WIDTH{1'b1}} << w_dist);
    out         = in;
    if (en) begin
      out = (in << w_dist) | (fill ? w_fill_mask : '0);
    end
  end

endmodule
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | shift_sequencer : two-requester round-robin front end around an         |
// |                   iterative log shifter with a valid/ready response     |
// | Revision        : 1.0                                                   |
// +-------------------------------------------------------------------------+
module shift_sequencer
  import shifter_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [SHAMT_W-1:0] req0_b,
  input  logic [1:0]         req0_ctl,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [SHAMT_W-1:0] req1_b,
  input  logic [1:0]         req1_ctl,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [WIDTH-1:0]   resp_data,
  output logic               resp_id
);

  logic [1:0]         r_state;
  logic [SHAMT_W-1:0] r_k;
  logic [WIDTH-1:0]   r_work;
  logic [SHAMT_W-1:0] r_b;
  logic               r_right;
  logic               r_fill;
  logic               r_id;
  logic               r_last_grant;

  logic               w_idle;
  logic               w_grant;
  logic               w_accept;
  logic [WIDTH-1:0]   w_sel_a;
  logic [SHAMT_W-1:0] w_sel_b;
  logic [1:0]         w_sel_ctl;
  logic               w_sel_right;
  logic               w_sel_fill;
  logic [WIDTH-1:0]   w_load;
  logic [WIDTH-1:0]   w_stage_out;
  logic [WIDTH-1:0]   w_result;

  // Arbitration: on contention the requester that did not win last time goes.
  always_comb begin
    w_idle     = (r_state == ST_IDLE);
    w_grant    = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
    req0_ready = w_idle && req0_valid && !w_grant;
    req1_ready = w_idle && req1_valid && w_grant;
    w_accept   = req0_ready || req1_ready;
  end

  // Right shifts run through the same left-shift datapath on reversed data.
  always_comb begin
    w_sel_a     = w_grant ? req1_a   : req0_a;
    w_sel_b     = w_grant ? req1_b   : req0_b;
    w_sel_ctl   = w_grant ? req1_ctl : req0_ctl;
    w_sel_right = w_sel_ctl[CTL_RIGHT];
    w_sel_fill  = w_sel_ctl[CTL_RIGHT] && w_sel_ctl[CTL_ARITH] && w_sel_a[WIDTH-1];
    w_load      = w_sel_right ? WIDTH'(bit_reverse(MAX_WIDTH'(w_sel_a), WIDTH)) : w_sel_a;
    w_result    = r_right ? WIDTH'(bit_reverse(MAX_WIDTH'(r_work), WIDTH)) : r_work;
  end

  shift_stage #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_stage (
    .in   (r_work),
    .k    (r_k),
    .en   (r_b[r_k]),
    .fill (r_fill),
    .out  (w_stage_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_k          <= '0;
      r_work       <= '0;
      r_b          <= '0;
      r_right      <= 1'b0;
      r_fill       <= 1'b0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      resp_id      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_work       <= w_load;
            r_b          <= w_sel_b;
            r_right      <= w_sel_right;
            r_fill       <= w_sel_fill;
            r_id         <= w_grant;
            r_last_grant <= w_grant;
            r_k          <= '0;
            r_state      <= ST_STAGE;
          end
        end
        ST_STAGE: begin
          r_work <= w_stage_out;
          // Every stage takes a cycle, even when its shift bit is clear
          if (r_k == SHAMT_W'(SHAMT_W - 1)) begin
            r_k     <= '0;
            r_state <= ST_FLIP;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        ST_FLIP: begin
          resp_data  <= w_result;
          resp_id    <= r_id;
          resp_valid <= 1'b1;
          r_state    <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_shift_sequencer : scoreboard bench for shift_sequencer               |
// | Revision           : 1.0                                                |
// +-------------------------------------------------------------------------+
module tb_shift_sequencer;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               req0_valid = 1'b0;
  logic               req0_ready;
  logic [WIDTH-1:0]   req0_a = '0;
  logic [SHAMT_W-1:0] req0_b = '0;
  logic [1:0]         req0_ctl = '0;
  logic               req1_valid = 1'b0;
  logic               req1_ready;
  logic [WIDTH-1:0]   req1_a = '0;
  logic [SHAMT_W-1:0] req1_b = '0;
  logic [1:0]         req1_ctl = '0;
  logic               resp_valid;
  logic               resp_ready = 1'b1;
  logic [WIDTH-1:0]   resp_data;
  logic               resp_id;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [WIDTH:0] exp_q[$];
  int             grant_log[$];
  int             acc_cyc[$];
  logic           acc0, acc1;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ctl   (req0_ctl),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ctl   (req1_ctl),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id)
  );

  // Reference behaviour built from the language shift operators.
  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a,
                                             input logic [SHAMT_W-1:0] b,
                                             input logic [1:0] ctl);
    if (ctl == 2'b11) return $unsigned($signed(a) >>> b);
    if (ctl == 2'b10) return a >> b;
    return a << b;
  endfunction

  // One clock: sample handshakes at the falling edge, then step past the rising edge.
  task automatic cycle();
    logic [WIDTH:0] e;
    acc0 = 1'b0;
    acc1 = 1'b0;
    @(negedge clk);
    if (reset) begin
      exp_q.delete();
    end else begin
      if (req0_ready && req1_ready) begin
        checks++; failures++;
        $display("FAIL dual_ready: both readys high at cycle %0d, expected at most one", cyc);
      end
      if (req0_ready) begin
        exp_q.push_back({1'b0, model(req0_a, req0_b, req0_ctl)});
        acc0 = 1'b1;
      end
      if (req1_ready) begin
        exp_q.push_back({1'b1, model(req1_a, req1_b, req1_ctl)});
        acc1 = 1'b1;
      end
      if (resp_valid && resp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: got id=%0d data=%h, expected no response", resp_id, resp_data);
        end else begin
          e = exp_q.pop_front();
          if ({resp_id, resp_data} !== e) begin
            failures++;
            $display("FAIL sb_result: got id=%0d data=%h, expected id=%0d data=%h",
                     resp_id, resp_data, e[WIDTH], e[WIDTH-1:0]);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (acc0 || acc1) begin
      grant_log.push_back(acc1 ? 1 : 0);
      acc_cyc.push_back(cyc);
    end
  endtask

  task automatic drive(input bit n, input logic v, input logic [WIDTH-1:0] a,
                       input logic [SHAMT_W-1:0] b, input logic [1:0] c);
    if (n == 1'b0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_ctl = c;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_ctl = c;
    end
  endtask

  task automatic wait_accept(input bit n);
    int t;
    bit ok;
    t = 0; ok = 1'b0;
    while (t < 30 && !ok) begin
      cycle();
      t++;
      ok = (n == 1'b0) ? acc0 : acc1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout: requester %0d not accepted in %0d cycles, expected acceptance", n, t);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!resp_valid && n < 30) begin
      cycle();
      n++;
    end
    checks++;
    if (!resp_valid) begin
      failures++;
      $display("FAIL valid_timeout: resp_valid=0 after %0d cycles, expected 1", n);
    end
  endtask

  // Issues one op, drops the request with scrambled operands, checks latency and result.
  task automatic do_op(input bit n, input logic [WIDTH-1:0] a, input logic [SHAMT_W-1:0] b,
                       input logic [1:0] ctl, input logic [WIDTH-1:0] expd, input string name);
    int lat;
    drive(n, 1'b1, a, b, ctl);
    wait_accept(n);
    drive(n, 1'b0, $urandom, SHAMT_W'($urandom), 2'($urandom));
    wait_valid(lat);
    checks++;
    if (lat != SHAMT_W + 1) begin
      failures++;
      $display("FAIL %s_latency: valid %0d edges after accept, expected %0d", name, lat, SHAMT_W + 1);
    end
    checks++;
    if (resp_data !== expd || resp_id !== n) begin
      failures++;
      $display("FAIL %s: got id=%0d data=%h, expected id=%0d data=%h", name, resp_id, resp_data, n, expd);
    end
    cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cycle();
    checks++;
    if (resp_valid !== 1'b0 || resp_data !== '0 || resp_id !== 1'b0) begin
      failures++;
      $display("FAIL reset_resp: got valid=%b data=%h id=%b, expected 0 0 0", resp_valid, resp_data, resp_id);
    end
    reset = 1'b0;
    cycle();
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: got ready0=%b ready1=%b, expected 0 0", req0_ready, req1_ready);
    end
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_valid: got %b, expected 0", resp_valid);
    end
  endtask

  task automatic test_single();
    do_op(1'b0, 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, "left_31");
  endtask

  task automatic test_modes();
    do_op(1'b1, 32'h8000_0000, 5'd4,  2'b11, 32'hF800_0000, "arith_right");
    do_op(1'b1, 32'h8000_0000, 5'd4,  2'b10, 32'h0800_0000, "logic_right");
    do_op(1'b1, 32'hFFFF_FFFF, 5'd1,  2'b01, 32'hFFFF_FFFE, "ctl01_left");
    do_op(1'b0, 32'hDEAD_BEEF, 5'd0,  2'b10, 32'hDEAD_BEEF, "b_zero");
    do_op(1'b0, 32'h8000_0000, 5'd31, 2'b10, 32'h0000_0001, "right_31");
    do_op(1'b0, 32'h8000_0000, 5'd31, 2'b11, 32'hFFFF_FFFF, "arith_31");
  endtask

  task automatic test_back_to_back();
    int t;
    reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    grant_log.delete();
    acc_cyc.delete();
    drive(1'b0, 1'b1, 32'h1234_5678, 5'd3, 2'b00);
    drive(1'b1, 1'b1, 32'h8765_4321, 5'd5, 2'b11);
    t = 0;
    while (grant_log.size() < 4 && t < 80) begin
      cycle();
      t++;
      if (acc0) drive(1'b0, 1'b1, $urandom, SHAMT_W'($urandom), 2'($urandom));
      if (acc1) drive(1'b1, 1'b1, $urandom, SHAMT_W'($urandom), 2'($urandom));
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checks++;
    if (grant_log.size() != 4) begin
      failures++;
      $display("FAIL b2b_count: got %0d accepts, expected 4", grant_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (grant_log[i] != (i % 2)) begin
          failures++;
          $display("FAIL b2b_grant%0d: got %0d, expected %0d", i, grant_log[i], i % 2);
        end
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (acc_cyc[i] - acc_cyc[i-1] != SHAMT_W + 3) begin
          failures++;
          $display("FAIL b2b_spacing%0d: got %0d cycles, expected %0d",
                   i, acc_cyc[i] - acc_cyc[i-1], SHAMT_W + 3);
        end
      end
    end
    t = 0;
    while (exp_q.size() > 0 && t < 40) begin
      cycle();
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_drain: %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int             lat;
    logic [WIDTH-1:0] sd;
    logic           sid;
    resp_ready = 1'b0;
    drive(1'b0, 1'b1, 32'hA5A5_A5A5, 5'd7, 2'b10);
    wait_accept(1'b0);
    drive(1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b1, 32'h0000_FFFF, 5'd16, 2'b00);
    wait_valid(lat);
    sd  = resp_data;
    sid = resp_id;
    checks++;
    if (sd !== 32'h014B_4B4B || sid !== 1'b0) begin
      failures++;
      $display("FAIL bp_result: got id=%0d data=%h, expected id=0 data=014b4b4b", sid, sd);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== sd || resp_id !== sid || req1_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d: got valid=%b data=%h id=%b ready1=%b, expected 1 %h %b 0",
                 i, resp_valid, resp_data, resp_id, req1_ready, sd, sid);
      end
    end
    resp_ready = 1'b1;
    cycle();
    checks++;
    if (resp_valid !== 1'b0 || req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: got valid=%b ready1=%b, expected 0 1", resp_valid, req1_ready);
    end
    cycle();
    checks++;
    if (acc1 !== 1'b1) begin
      failures++;
      $display("FAIL bp_resume: got accept1=%b, expected 1", acc1);
    end
    drive(1'b1, 1'b0, '0, '0, '0);
    wait_valid(lat);
    cycle();
  endtask

  task automatic test_reset_abort();
    int lat;
    drive(1'b0, 1'b1, 32'hFFFF_0000, 5'd9, 2'b11);
    wait_accept(1'b0);
    drive(1'b0, 1'b0, '0, '0, '0);
    repeat (2) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      checks++;
      if (resp_valid !== 1'b0) begin
        failures++;
        $display("FAIL abort_valid%0d: got resp_valid=%b, expected 0", i, resp_valid);
      end
    end
    grant_log.delete();
    drive(1'b0, 1'b1, 32'h0000_00F0, 5'd2, 2'b10);
    drive(1'b1, 1'b1, 32'h0000_000F, 5'd2, 2'b00);
    for (int i = 0; i < 10 && grant_log.size() == 0; i++) cycle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checks++;
    if (grant_log.size() != 1 || grant_log[0] != 0) begin
      failures++;
      $display("FAIL abort_regrant: got %0d grants first=%0d, expected 1 grant to 0",
               grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : -1);
    end
    wait_valid(lat);
    cycle();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL abort_drain: %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
